// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK register bank.
package jk_pkg;

   localparam int JK_MODE_W = 2;

   typedef enum logic [JK_MODE_W-1:0] {
      JK_MODE_JK    = 2'b00,
      JK_MODE_LOAD  = 2'b01,
      JK_MODE_COUNT = 2'b10,
      JK_MODE_HOLD  = 2'b11
   } jk_mode_t;

   // Next state of a single JK flip-flop.
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      case ({j, k})
         2'b00:   return q;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~q;
      endcase
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with clock enable and synchronous reset to a per-bit value.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rst_val,
   input  logic ce,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (ce) q_d = jk_next(q_q, j, k);
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= rst_val;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK cells with JK / LOAD / COUNT / HOLD modes, terminal-count and changed flags.
// Define JK_REG_BANK_CNT_EN to build the COUNT mode and tc; otherwise mode 10 holds and tc is 0.
module jk_reg_bank
   import jk_pkg::*;
#(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [JK_MODE_W-1:0]  mode,
   input  logic [WIDTH-1:0]      j,
   input  logic [WIDTH-1:0]      k,
   input  logic [WIDTH-1:0]      d,
   input  logic                  up,
   output logic [WIDTH-1:0]      q,
   output logic [WIDTH-1:0]      qbar,
   output logic                  tc,
   output logic                  changed
);

   logic             ce;
   logic [WIDTH-1:0] j_eff;
   logic [WIDTH-1:0] k_eff;
   logic [WIDTH-1:0] q_next;
   logic             chg_d;
   logic             chg_q;
   logic             tc_d;

`ifdef JK_REG_BANK_CNT_EN
   logic [WIDTH-1:0] tog;
   logic             run;
   logic             tc_q;

   // Ripple toggle-enable: bit i toggles when all lower bits are 1 (up) or 0 (down);
   // the carry out of the top bit is exactly the wrap condition.
   always_comb begin
      run = 1'b1;
      tog = '0;
      for (int i = 0; i < WIDTH; i++) begin
         tog[i] = run;
         run    = run & (up ? q[i] : ~q[i]);
      end
   end
`else
   logic unused_up;
   assign unused_up = up;
`endif

   always_comb begin
      ce    = en;
      j_eff = j;
      k_eff = k;
      tc_d  = 1'b0;
      case (mode)
         JK_MODE_JK: ;
         JK_MODE_LOAD: begin
            j_eff = d;
            k_eff = ~d;
         end
         JK_MODE_COUNT: begin
`ifdef JK_REG_BANK_CNT_EN
            j_eff = tog;
            k_eff = tog;
            tc_d  = en & run;
`else
            ce = 1'b0;
`endif
         end
         JK_MODE_HOLD: ce = 1'b0;
      endcase
   end

   // Mirror of the cells' next state, used only to detect a value change.
   always_comb begin
      q_next = q;
      for (int i = 0; i < WIDTH; i++)
         if (ce) q_next[i] = jk_next(q[i], j_eff[i], k_eff[i]);
      chg_d = (q_next != q);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .rst_val (RST_VAL[i]),
         .ce      (ce),
         .j       (j_eff[i]),
         .k       (k_eff[i]),
         .q       (q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) chg_q <= 1'b0;
      else     chg_q <= chg_d;
   end

`ifdef JK_REG_BANK_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) tc_q <= 1'b0;
      else     tc_q <= tc_d;
   end
   assign tc = tc_q;
`else
   logic unused_tc_d;
   assign unused_tc_d = tc_d;
   assign tc = 1'b0;
`endif

   assign changed = chg_q;
   assign qbar    = ~q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=4, RST_VAL=0); COUNT checks follow JK_REG_BANK_CNT_EN.
module tb_jk_reg_bank;

   localparam int W = 4;
   localparam logic [1:0] M_JK = 2'b00, M_LD = 2'b01, M_CNT = 2'b10, M_HLD = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, en, up;
   logic [1:0]   mode;
   logic [W-1:0] j, k, d, q, qbar;
   logic         tc, changed;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] qbar;
      logic         tc;
      logic         chg;
   } obs_t;

   typedef struct packed {
      logic         rst;
      logic         en;
      logic [1:0]   mode;
      logic [W-1:0] j;
      logic [W-1:0] k;
      logic [W-1:0] d;
      logic         up;
   } stim_t;

   obs_t         sb[$];
   logic [W-1:0] mq;
   int           errors = 0;
   int           checks = 0;

   jk_reg_bank #(.WIDTH(W), .RST_VAL(4'h0)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .j       (j),
      .k       (k),
      .d       (d),
      .up      (up),
      .q       (q),
      .qbar    (qbar),
      .tc      (tc),
      .changed (changed)
   );

   function automatic stim_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [W-1:0] jj, input logic [W-1:0] kk,
                                input logic [W-1:0] dd, input logic u);
      stim_t s;
      s.rst = r; s.en = e; s.mode = m; s.j = jj; s.k = kk; s.d = dd; s.up = u;
      return s;
   endfunction

   // Drive one cycle of stimulus, push the model's expectation, and advance past the edge.
   task automatic apply(input stim_t s);
      obs_t         e;
      logic [W-1:0] nq;
      rst = s.rst; en = s.en; mode = s.mode; j = s.j; k = s.k; d = s.d; up = s.up;
      nq   = mq;
      e.tc = 1'b0;
      if (s.rst) nq = 4'h0;
      else if (s.en) begin
         case (s.mode)
            M_JK: for (int b = 0; b < W; b++)
               if (s.j[b] && s.k[b]) nq[b] = ~mq[b];
               else if (s.j[b])      nq[b] = 1'b1;
               else if (s.k[b])      nq[b] = 1'b0;
            M_LD: nq = s.d;
`ifdef JK_REG_BANK_CNT_EN
            M_CNT: begin
               nq   = s.up ? mq + 4'd1 : mq - 4'd1;
               e.tc = s.up ? (mq == 4'hF) : (mq == 4'h0);
            end
`endif
            default: ;
         endcase
      end
      e.chg  = !s.rst && (nq !== mq);
      e.q    = nq;
      e.qbar = ~nq;
      mq     = nq;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t st[$];
      obs_t  got, exp;
      st.push_back(mk(1, 1, M_LD, 4'($urandom), 4'($urandom), 4'hF, 1));
      st.push_back(mk(1, 0, M_JK, 4'hF, 4'hF, 4'hF, 0));
      foreach (st[i]) begin
         apply(st[i]);
         got = {q, qbar, tc, changed};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset step%0d q/qbar/tc/chg got %h/%h/%b/%b want %h/%h/%b/%b",
                     i, got.q, got.qbar, got.tc, got.chg, exp.q, exp.qbar, exp.tc, exp.chg);
         end
      end
   endtask

   task automatic test_jk();
      stim_t st[$];
      obs_t  got, exp;
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'h5, 0));
      st.push_back(mk(0, 1, M_JK, 4'h3, 4'hC, 4'h0, 0));
      st.push_back(mk(0, 1, M_JK, 4'h0, 4'h0, 4'hF, 0));
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'hA, 0));
      st.push_back(mk(0, 1, M_JK, 4'hF, 4'hF, 4'h0, 0));
      st.push_back(mk(0, 1, M_JK, 4'hF, 4'hF, 4'h0, 0));
      st.push_back(mk(0, 1, M_JK, 4'hA, 4'h5, 4'h0, 0));
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'hA, 0));
      st.push_back(mk(0, 1, M_JK, 4'h9, 4'h6, 4'h0, 0));
      foreach (st[i]) begin
         apply(st[i]);
         got = {q, qbar, tc, changed};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL jk step%0d q/qbar/tc/chg got %h/%h/%b/%b want %h/%h/%b/%b",
                     i, got.q, got.qbar, got.tc, got.chg, exp.q, exp.qbar, exp.tc, exp.chg);
         end
      end
   endtask

   task automatic test_hold();
      stim_t st[$];
      obs_t  got, exp;
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'h5, 0));
      st.push_back(mk(0, 0, M_JK, 4'hF, 4'hF, 4'h0, 0));
      st.push_back(mk(0, 1, M_HLD, 4'hF, 4'hF, 4'hA, 1));
      st.push_back(mk(0, 0, M_LD, 4'h0, 4'h0, 4'hA, 0));
      foreach (st[i]) begin
         apply(st[i]);
         got = {q, qbar, tc, changed};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL hold step%0d q/qbar/tc/chg got %h/%h/%b/%b want %h/%h/%b/%b",
                     i, got.q, got.qbar, got.tc, got.chg, exp.q, exp.qbar, exp.tc, exp.chg);
         end
      end
   endtask

   task automatic test_count();
      stim_t st[$];
      obs_t  got, exp;
`ifdef JK_REG_BANK_CNT_EN
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'hE, 0));
      repeat (3) st.push_back(mk(0, 1, M_CNT, 4'h0, 4'h0, 4'h0, 1));
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'h1, 0));
      repeat (3) st.push_back(mk(0, 1, M_CNT, 4'h0, 4'h0, 4'h0, 0));
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'h7, 0));
      repeat (3) st.push_back(mk(0, 0, M_CNT, 4'h0, 4'h0, 4'h0, 1));
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'h8, 0));
      st.push_back(mk(0, 1, M_CNT, 4'h0, 4'h0, 4'h0, 1));
      st.push_back(mk(1, 1, M_CNT, 4'h0, 4'h0, 4'h0, 1));
      st.push_back(mk(0, 1, M_CNT, 4'h0, 4'h0, 4'h0, 1));
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'hF, 0));
      st.push_back(mk(0, 1, M_CNT, 4'h0, 4'h0, 4'h0, 1));
      st.push_back(mk(0, 0, M_CNT, 4'h0, 4'h0, 4'h0, 1));
`else
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'h3, 0));
      repeat (4) st.push_back(mk(0, 1, M_CNT, 4'h0, 4'h0, 4'h0, 1));
      st.push_back(mk(0, 1, M_LD, 4'h0, 4'h0, 4'hF, 0));
      st.push_back(mk(0, 1, M_CNT, 4'hF, 4'hF, 4'h0, 1));
`endif
      foreach (st[i]) begin
         apply(st[i]);
         got = {q, qbar, tc, changed};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL count step%0d q/qbar/tc/chg got %h/%h/%b/%b want %h/%h/%b/%b",
                     i, got.q, got.qbar, got.tc, got.chg, exp.q, exp.qbar, exp.tc, exp.chg);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t  got, exp;
      stim_t s;
      for (int i = 0; i < 60; i++) begin
         s = mk(($urandom_range(0, 15) == 0), ($urandom_range(0, 4) != 0), 2'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         apply(s);
         got = {q, qbar, tc, changed};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL b2b step%0d q/qbar/tc/chg got %h/%h/%b/%b want %h/%h/%b/%b",
                     i, got.q, got.qbar, got.tc, got.chg, exp.q, exp.qbar, exp.tc, exp.chg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_jk();
      test_hold();
      test_count();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of JK bits (1..32).
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit reset value of q.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 en  in  1  update enable; 0 = hold all state except rst.
REQ-007 mode  in  2  operation select: 00 JK, 01 LOAD, 10 COUNT, 11 HOLD.
REQ-008 j  in  WIDTH  per-bit J inputs (JK mode).
REQ-009 k  in  WIDTH  per-bit K inputs (JK mode).
REQ-010 d  in  WIDTH  parallel load data (LOAD mode).
REQ-011 up  in  1  count direction in COUNT mode: 1 up, 0 down.
REQ-012 q  out  WIDTH  registered state.
REQ-013 qbar  out  WIDTH  combinational bitwise inverse of q.
REQ-014 tc  out  1  registered terminal-count pulse.
REQ-015 changed  out  1  registered flag: q changed value on the last edge.

Function
REQ-016 All state SHALL update only on rising clk; priority rst > en=0 > mode.
REQ-017 JK mode, per bit i: (j,k)=00 hold, 01 clear, 10 set, 11 toggle; bits independent.
REQ-018 LOAD mode SHALL set q <= d on the edge.
REQ-019 COUNT mode SHALL set q <= q+1 (up=1) or q-1 (up=0), modulo 2^WIDTH, built as bit i toggling when all lower bits are 1 (up) or all 0 (down).
REQ-020 HOLD mode and en=0 SHALL leave q unchanged.
REQ-021 tc SHALL be 1 for exactly the cycle after an edge where COUNT wrapped (all-ones->0 up, 0->all-ones down), else 0.
REQ-022 changed SHALL be 1 for the cycle after any edge where new q != old q, else 0; a no-op toggle pattern or a load of equal data gives 0.
REQ-023 With en=0, tc and changed SHALL be 0 on the next cycle.
REQ-024 A mode change between cycles SHALL take effect on the very next edge; no pipeline, latency 1 cycle from input to q.
REQ-025 qbar SHALL equal ~q at all times, including during reset.

Reset
REQ-026 rst=1 on an edge SHALL set q=RST_VAL, tc=0, changed=0, overriding en, mode and all data inputs.
REQ-027 Reset asserted mid-count SHALL abort the count; counting resumes from RST_VAL once rst=0.
REQ-028 Before the first reset edge, outputs are undefined; benches SHALL reset first.

Configuration
REQ-029 Macro JK_REG_BANK_CNT_EN defined: COUNT mode and tc behave per REQ-019/REQ-021.
REQ-030 Macro undefined: mode 10 SHALL behave as HOLD, tc SHALL be tied 0, up ignored; no counter carry logic synthesised.

Structure
REQ-031 Shared package jk_pkg SHALL hold typedef jk_mode_t (JK_MODE_JK, JK_MODE_LOAD, JK_MODE_COUNT, JK_MODE_HOLD) and the 2-bit mode width constant.
REQ-032 Sub-module jk_cell SHALL implement one bit: clk, rst, rst_val, ce, j, k, q; jk_reg_bank instantiates WIDTH cells, mapping LOAD to j=d,k=~d and COUNT to j=k=toggle-enable.
REQ-033 tc and changed registers SHALL live in jk_reg_bank, not in jk_cell.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-034 rst=1 with mode=01,d=F -> q=0, qbar=F, tc=0, changed=0.
REQ-035 JK mode, q=0101, j=0011,k=1100 -> q=0011, changed=1; then j=k=0000 -> q=0011, changed=0.
REQ-036 JK mode, q=1010, j=k=1111 -> q=0101; repeat -> q=1010.
REQ-037 COUNT up from q=E: q=F tc=0, then q=0 tc=1, then q=1 tc=0; down from 0 -> F with tc=1.
REQ-038 COUNT with en=0 for 3 cycles at q=7 -> q stays 7, changed=0, tc=0; rst mid-count at q=9 -> q=0 next cycle.
REQ-039 Build without JK_REG_BANK_CNT_EN: mode=10,up=1 at q=3 for 4 cycles -> q=3, tc=0 throughout.
